// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the VGA raster generator (640x480@60 Hz at a
// 25 MHz pixel clock), the totals derived from them, the sync-window bounds
// and a helper that maps a sync-window hit onto the configured pin polarity.
// No ports: imported by vga_axis_counter and vga_hvsync_generator.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Beam counter width; every axis total must fit in it.
  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  // Horizontal timing, in pixels.
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  // Vertical timing, in lines.
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // Sync active levels (0 = active-low).
  localparam logic H_SYNC_POL_DEF = 1'b0;
  localparam logic V_SYNC_POL_DEF = 1'b0;

  // Derived totals.
  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync windows: start inclusive, end exclusive.
  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Pin level for a sync output: active level inside the window, idle outside.
  function automatic logic sync_level(input logic in_window, input logic pol);
    logic level;
    if (in_window) begin
      level = pol;
    end else begin
      level = ~pol;
    end
    return level;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a 0..TOTAL-1 wrap counter with enable, a terminal-count
// flag and a registered sync-window decode. The visible-window decode of the
// next count is exported so the top can register the 2-D visible flag.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous, active-high
//   en           in   advance the counter on this edge
//   pos          out  registered beam position
//   tc           out  pos is at TOTAL-1 (combinational, for cascading)
//   sync         out  registered sync level for pos
//   visible_next out  next position lies in 0..DISPLAY-1
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   TOTAL      = H_TOTAL_DEF,
  parameter int   DISPLAY    = H_DISPLAY_DEF,
  parameter int   SYNC_START = H_SYNC_START_DEF,
  parameter int   SYNC_END   = H_SYNC_END_DEF,
  parameter logic SYNC_POL   = H_SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             tc,
  output logic             sync,
  output logic             visible_next
);

  localparam logic [POS_W-1:0] LAST_V       = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] DISPLAY_V    = POS_W'(DISPLAY);
  localparam logic [POS_W-1:0] SYNC_START_V = POS_W'(SYNC_START);
  localparam logic [POS_W-1:0] SYNC_END_V   = POS_W'(SYNC_END);

  logic [POS_W-1:0] pos_r;
  logic             sync_r;
  logic [POS_W-1:0] pos_next_s;
  logic             tc_s;
  logic             sync_next_s;

  // Next count and decodes of that next count, so registered outputs line up
  // with the registered position.
  always_comb begin
    tc_s = (pos_r == LAST_V);
    if (!en) begin
      pos_next_s = pos_r;
    end else if (tc_s) begin
      pos_next_s = {POS_W{1'b0}};
    end else begin
      pos_next_s = pos_r + {{(POS_W-1){1'b0}}, 1'b1};
    end
    sync_next_s  = sync_level((pos_next_s >= SYNC_START_V) && (pos_next_s < SYNC_END_V),
                              SYNC_POL);
    visible_next = (pos_next_s < DISPLAY_V);
  end

  // Position and sync registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_r  <= {POS_W{1'b0}};
      sync_r <= ~SYNC_POL;
    end else begin
      pos_r  <= pos_next_s;
      sync_r <= sync_next_s;
    end
  end

  assign pos  = pos_r;
  assign tc   = tc_s;
  assign sync = sync_r;

endmodule

// File: rtl/vga_hvsync_generator.sv
// -----------------------------------------------------------------------------
// vga_hvsync_generator
// VGA raster timing generator. Two cascaded axis counters produce the beam
// position and sync pulses; the 2-D flags are registered here from the next
// counter state so every output describes the current (hpos, vpos).
//
// Ports:
//   clk          in   pixel clock (25 MHz)
//   reset        in   asynchronous, active-high
//   pix_ce       in   pixel clock enable (tie high if clk is the pixel clock)
//   hpos         out  horizontal position 0..H_TOTAL-1
//   vpos         out  vertical position 0..V_TOTAL-1
//   hsync        out  horizontal sync, level per H_SYNC_POL
//   vsync        out  vertical sync, level per V_SYNC_POL
//   display_on   out  (hpos, vpos) inside the visible area
//   line_start   out  high while hpos == 0
//   frame_start  out  high while hpos == 0 and vpos == 0
// -----------------------------------------------------------------------------
module vga_hvsync_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY  = H_DISPLAY_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_DISPLAY  = V_DISPLAY_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter logic H_SYNC_POL = H_SYNC_POL_DEF,
  parameter logic V_SYNC_POL = V_SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
    $error("vga_hvsync_generator: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
    $error("vga_hvsync_generator: V_TOTAL exceeds counter range");
  end

  logic h_tc_s;
  logic v_tc_s;
  logic v_en_s;
  logic h_vis_next_s;
  logic v_vis_next_s;
  logic display_on_r;
  logic line_start_r;
  logic frame_start_r;
  logic line_start_next_s;
  logic frame_start_next_s;

  // The vertical axis steps only on the enabled edge that wraps a line.
  assign v_en_s = pix_ce & h_tc_s;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .DISPLAY    (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC),
    .SYNC_POL   (H_SYNC_POL)
  ) u_h_axis (
    .clk          (clk),
    .reset        (reset),
    .en           (pix_ce),
    .pos          (hpos),
    .tc           (h_tc_s),
    .sync         (hsync),
    .visible_next (h_vis_next_s)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .DISPLAY    (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC),
    .SYNC_POL   (V_SYNC_POL)
  ) u_v_axis (
    .clk          (clk),
    .reset        (reset),
    .en           (v_en_s),
    .pos          (vpos),
    .tc           (v_tc_s),
    .sync         (vsync),
    .visible_next (v_vis_next_s)
  );

  // The next position is (0, *) only via a line wrap and (0, 0) only via a
  // frame wrap, so the start flags follow from the terminal counts.
  always_comb begin
    if (pix_ce) begin
      line_start_next_s  = h_tc_s;
      frame_start_next_s = h_tc_s & v_tc_s;
    end else begin
      line_start_next_s  = line_start_r;
      frame_start_next_s = frame_start_r;
    end
  end

  // Registered 2-D flags; reset describes position (0, 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_on_r  <= 1'b1;
      line_start_r  <= 1'b1;
      frame_start_r <= 1'b1;
    end else begin
      display_on_r  <= h_vis_next_s & v_vis_next_s;
      line_start_r  <= line_start_next_s;
      frame_start_r <= frame_start_next_s;
    end
  end

  assign display_on  = display_on_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_hvsync_generator
// Scoreboard bench: the stimulus process advances a reference position for each
// DUT and queues the expected outputs; a monitor pops and compares after every
// rising edge. A second instance uses a tiny raster with inverted sync
// polarities so whole frames and mid-frame reset fit in a short run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_hvsync_generator;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b0;

  logic [9:0] b_hpos, b_vpos, s_hpos, s_vpos;
  logic b_hsync, b_vsync, b_de, b_ls, b_fs;
  logic s_hsync, s_vsync, s_de, s_ls, s_fs;

  int total = 0;
  int bad = 0;

  exp_t q_big[$];
  exp_t q_small[$];

  // Reference positions.
  int bh = 0, bv = 0, sh = 0, sv = 0;

  always #5 clk = ~clk;

  vga_hvsync_generator dut_big (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .display_on(b_de), .line_start(b_ls), .frame_start(b_fs)
  );

  // Small raster: H 8+2+3+3 = 16, V 4+1+2+2 = 9, active-high syncs.
  vga_hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_small (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
    .display_on(s_de), .line_start(s_ls), .frame_start(s_fs)
  );

  function automatic exp_t exp_big(input int h, input int v);
    exp_t e;
    e.h  = h[9:0];
    e.v  = v[9:0];
    e.hs = (h >= 656 && h < 752) ? 1'b0 : 1'b1;
    e.vs = (v >= 490 && v < 492) ? 1'b0 : 1'b1;
    e.de = (h < 640) && (v < 480);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t exp_small(input int h, input int v);
    exp_t e;
    e.h  = h[9:0];
    e.v  = v[9:0];
    e.hs = (h >= 10 && h < 13) ? 1'b1 : 1'b0;
    e.vs = (v >= 5 && v < 7) ? 1'b1 : 1'b0;
    e.de = (h < 8) && (v < 4);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input exp_t a, input exp_t e);
    cmp({tag, ".hpos"}, 32'(a.h), 32'(e.h));
    cmp({tag, ".vpos"}, 32'(a.v), 32'(e.v));
    cmp({tag, ".hsync"}, 32'(a.hs), 32'(e.hs));
    cmp({tag, ".vsync"}, 32'(a.vs), 32'(e.vs));
    cmp({tag, ".display_on"}, 32'(a.de), 32'(e.de));
    cmp({tag, ".line_start"}, 32'(a.ls), 32'(e.ls));
    cmp({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
  endtask

  function automatic exp_t act_big();
    return '{b_hpos, b_vpos, b_hsync, b_vsync, b_de, b_ls, b_fs};
  endfunction

  function automatic exp_t act_small();
    return '{s_hpos, s_vpos, s_hsync, s_vsync, s_de, s_ls, s_fs};
  endfunction

  // Monitor: one expected entry per DUT per clock edge.
  always @(posedge clk) begin
    #1;
    if (q_big.size() > 0) check_vec("big", act_big(), q_big.pop_front());
    if (q_small.size() > 0) check_vec("small", act_small(), q_small.pop_front());
  end

  // One clock: drive pix_ce at the falling edge, advance the references, queue.
  task automatic step(input logic ce);
    @(negedge clk);
    pix_ce = ce;
    if (ce) begin
      bh++;
      if (bh == 800) begin
        bh = 0;
        bv++;
        if (bv == 525) bv = 0;
      end
      sh++;
      if (sh == 16) begin
        sh = 0;
        sv++;
        if (sv == 9) sv = 0;
      end
    end
    q_big.push_back(exp_big(bh, bv));
    q_small.push_back(exp_small(sh, sv));
    @(posedge clk);
  endtask

  initial begin
    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #2;
    check_vec("rst_big", act_big(), exp_big(0, 0));
    check_vec("rst_small", act_small(), exp_small(0, 0));

    // Release; outputs stay at the origin until the first enabled edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_vec("rel_big", act_big(), exp_big(0, 0));

    // Continuous enable: two full lines plus 100 pixels on the big raster,
    // many whole frames on the small one.
    for (int i = 0; i < 1700; i++) step(1'b1);

    // Enable toggling every cycle: outputs must hold on disabled edges.
    for (int i = 0; i < 400; i++) step((i % 2) == 0);

    // Hand-computed positions: big 1900 advances -> (300, 2); small -> (12, 1).
    #2;
    cmp("spot_big_h", 32'(b_hpos), 32'd300);
    cmp("spot_big_v", 32'(b_vpos), 32'd2);
    cmp("spot_small_h", 32'(s_hpos), 32'd12);
    cmp("spot_small_v", 32'(s_vpos), 32'd1);

    // Asynchronous reset between clock edges.
    reset = 1'b1;
    #1;
    check_vec("async_big", act_big(), exp_big(0, 0));
    check_vec("async_small", act_small(), exp_small(0, 0));
    @(negedge clk);
    reset = 1'b0;
    bh = 0; bv = 0; sh = 0; sv = 0;
    for (int i = 0; i < 40; i++) step(1'b1);

    @(posedge clk);
    #2;
    cmp("queue_drained", 32'(q_big.size() + q_small.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
